// File: rtl/uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl
//
// Frame controller and serializer for the UART transmitter. Accepts a parallel
// word, sends it LSB first and computes its parity bit. It steers the TX output
// multiplexer through mux_sel (00 start, 01 data, 10 parity, 11 stop/idle).
// One bit is emitted per CLK cycle, so CLK is the baud-rate clock.
//
// Optional feature (compile-time macro UART_TX_HOLD_BUF_EN):
//   Adds a one-entry holding register (data, PAR_EN, PAR_TYP) so a word offered
//   while a frame is in flight is queued and sent straight after the current
//   STOP, with no idle cycle between the frames. Without the macro buf_full is
//   tied to 0 and words offered while busy are ignored.
//
// Ports
//   CLK         in   1           bit clock
//   RST         in   1           synchronous reset, active-high, highest priority
//   P_DATA      in   DATA_WIDTH  parallel word to transmit
//   Data_Valid  in   1           P_DATA valid (pulse or level)
//   PAR_EN      in   1           1 = insert parity bit
//   PAR_TYP     in   1           0 = even parity, 1 = odd parity
//   ser_data    out  1           current data bit, valid while mux_sel==01, else 0
//   par_bit     out  1           parity of the latched word, held for the frame
//   mux_sel     out  2           frame-field select to the TX mux
//   busy        out  1           frame in progress
//   buf_full    out  1           holding register occupied
//   dbg_state   out  3           current FSM state (debug/observation only)
//
// Handshake: there is no ready signal. A word is accepted on a rising edge
// where Data_Valid=1 and either the FSM is IDLE (word goes straight into the
// shifter) or, with the holding register built in, the register is free after
// that edge. Any other Data_Valid is dropped silently.
// -----------------------------------------------------------------------------
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic [1:0]            mux_sel,
  output logic                  busy,
  output logic                  buf_full,
  output logic [2:0]            dbg_state
);

  // A 1-bit payload still needs a 1-bit counter.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  ser_q, ser_d;
  logic [1:0]            mux_q, mux_d;
  logic                  busy_q, busy_d;

  // Frame-load request: when load_en is high the FSM moves to START on this
  // edge and the shifter/parity take the load_* values.
  logic                  load_en;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_par_en;
  logic                  load_par_typ;

`ifdef UART_TX_HOLD_BUF_EN
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_par_en_q, hold_par_en_d;
  logic                  hold_par_typ_q, hold_par_typ_d;
  logic                  buf_full_q, buf_full_d;
  logic                  launch_buf;
  logic                  launch_in;
  logic                  capture;

  always_comb begin
    // A queued word leaves from STOP (back-to-back) or from IDLE. The IDLE
    // case covers a word captured during the very STOP cycle that had
    // already decided to return to IDLE.
    launch_buf = buf_full_q && ((state_q == S_STOP) || (state_q == S_IDLE));
    // Direct acceptance only in IDLE with nothing queued ahead of it.
    launch_in  = (state_q == S_IDLE) && !buf_full_q && Data_Valid;
    // Capture when the register is free after this edge: either empty now,
    // or being emptied by a launch on this same edge.
    capture    = Data_Valid && !launch_in && (!buf_full_q || launch_buf);

    load_en      = launch_buf || launch_in;
    load_data    = launch_buf ? hold_data_q    : P_DATA;
    load_par_en  = launch_buf ? hold_par_en_q  : PAR_EN;
    load_par_typ = launch_buf ? hold_par_typ_q : PAR_TYP;

    hold_data_d    = hold_data_q;
    hold_par_en_d  = hold_par_en_q;
    hold_par_typ_d = hold_par_typ_q;
    buf_full_d     = buf_full_q;
    if (launch_buf) begin
      buf_full_d = 1'b0;
    end
    if (capture) begin
      hold_data_d    = P_DATA;
      hold_par_en_d  = PAR_EN;
      hold_par_typ_d = PAR_TYP;
      buf_full_d     = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_data_q    <= '0;
      hold_par_en_q  <= 1'b0;
      hold_par_typ_q <= 1'b0;
      buf_full_q     <= 1'b0;
    end else begin
      hold_data_q    <= hold_data_d;
      hold_par_en_q  <= hold_par_en_d;
      hold_par_typ_q <= hold_par_typ_d;
      buf_full_q     <= buf_full_d;
    end
  end

  assign buf_full = buf_full_q;
`else
  always_comb begin
    // Without a holding register only an idle controller accepts a word.
    load_en      = (state_q == S_IDLE) && Data_Valid;
    load_data    = P_DATA;
    load_par_en  = PAR_EN;
    load_par_typ = PAR_TYP;
  end

  assign buf_full = 1'b0;
`endif

  // Next-state and datapath. Outputs are computed from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    ser_d     = 1'b0;
    mux_d     = SEL_STOP;
    busy_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
      end
      S_STOP: begin
        state_d = load_en ? S_START : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Parity is fixed at load time and stays put for the whole frame, so a
    // mid-frame change of PAR_EN/PAR_TYP cannot disturb it.
    if (load_en) begin
      shift_d   = load_data;
      par_en_d  = load_par_en;
      par_bit_d = (^load_data) ^ load_par_typ;
    end

    // Each DATA cycle presents shift[0] and consumes it; ser_data stays 0
    // in every other field.
    if (state_d == S_DATA) begin
      ser_d   = shift_q[0];
      shift_d = shift_q >> 1;
    end

    case (state_d)
      S_START:  mux_d = SEL_START;
      S_DATA:   mux_d = SEL_DATA;
      S_PARITY: mux_d = SEL_PARITY;
      default:  mux_d = SEL_STOP;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      ser_q     <= 1'b0;
      mux_q     <= SEL_STOP;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      ser_q     <= ser_d;
      mux_q     <= mux_d;
      busy_q    <= busy_d;
    end
  end

  assign ser_data  = ser_q;
  assign par_bit   = par_bit_q;
  assign mux_sel   = mux_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame_ctrl
//
// Directed bench for uart_tx_frame_ctrl (DATA_WIDTH=8). Inputs are driven 1 ns
// after the rising edge and outputs are sampled at that same point, so every
// sample sees the state registered by the preceding edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_frame_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       ser_data;
  logic       par_bit;
  logic [1:0] mux_sel;
  logic       busy;
  logic       buf_full;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .Data_Valid (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .mux_sel    (mux_sel),
    .busy       (busy),
    .buf_full   (buf_full),
    .dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Offer one word with a single-cycle Data_Valid; returns with START visible.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".mux"},  mux_sel,  2'b11);
    check_eq({tag, ".busy"}, busy,     1'b0);
    check_eq({tag, ".ser"},  ser_data, 1'b0);
  endtask

  // Walk a whole frame, starting with START visible and ending one cycle
  // after STOP (IDLE visible). Optionally pulses a new word, and flips
  // PAR_EN/PAR_TYP, during DATA cycle inj_at.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                           input logic exp_par, input int inj_at, input logic [7:0] inj_d);
    check_eq({tag, ".start_mux"},  mux_sel,  2'b00);
    check_eq({tag, ".start_busy"}, busy,     1'b1);
    check_eq({tag, ".start_ser"},  ser_data, 1'b0);
    check_eq({tag, ".start_par"},  par_bit,  exp_par);
    tick();
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("%s.d%0d_mux", tag, i), mux_sel,  2'b01);
      check_eq($sformatf("%s.d%0d_ser", tag, i), ser_data, d[i]);
      check_eq($sformatf("%s.d%0d_par", tag, i), par_bit,  exp_par);
      check_eq($sformatf("%s.d%0d_busy", tag, i), busy,    1'b1);
      if (inj_at >= 0 && i == inj_at) begin
        p_data     = inj_d;
        data_valid = 1'b1;
        par_en     = ~par_en;
        par_typ    = ~par_typ;
      end else if (inj_at >= 0 && i == inj_at + 1) begin
        data_valid = 1'b0;
      end
      tick();
    end
    if (pe) begin
      check_eq({tag, ".par_mux"}, mux_sel,  2'b10);
      check_eq({tag, ".par_bit"}, par_bit,  exp_par);
      check_eq({tag, ".par_ser"}, ser_data, 1'b0);
      tick();
    end
    check_eq({tag, ".stop_mux"},  mux_sel, 2'b11);
    check_eq({tag, ".stop_busy"}, busy,    1'b1);
    check_eq({tag, ".stop_ser"},  ser_data, 1'b0);
    tick();
    check_idle({tag, ".after"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start_cycle;
    rst        = 1'b1;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    tick();
    tick();
    check_eq("rst.mux",   mux_sel,   2'b11);
    check_eq("rst.busy",  busy,      1'b0);
    check_eq("rst.ser",   ser_data,  1'b0);
    check_eq("rst.par",   par_bit,   1'b0);
    check_eq("rst.buf",   buf_full,  1'b0);
    check_eq("rst.state", dbg_state, 3'd0);
    rst = 1'b0;
    tick();
    check_idle("post_rst");

    // 0xA5 has four ones: even parity 0, odd parity 1.
    send(8'hA5, 1'b1, 1'b0);
    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, -1, 8'h00);
    send(8'hA5, 1'b1, 1'b1);
    run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, -1, 8'h00);
    // No parity field: START, 8 data, STOP = 10 cycles.
    send(8'hA5, 1'b0, 1'b0);
    run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, -1, 8'h00);
    // 0x01 has one 1: even parity gives par_bit 1.
    send(8'h01, 1'b1, 1'b0);
    run_frame("x01_even", 8'h01, 1'b1, 1'b1, -1, 8'h00);

    // Reset mid-frame: three cycles of RST inside DATA.
    send(8'hA5, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    check_eq("midrst.pre_mux", mux_sel, 2'b01);
    rst = 1'b1;
    tick();
    check_eq("midrst.mux",   mux_sel,   2'b11);
    check_eq("midrst.busy",  busy,      1'b0);
    check_eq("midrst.ser",   ser_data,  1'b0);
    check_eq("midrst.par",   par_bit,   1'b0);
    check_eq("midrst.state", dbg_state, 3'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_idle("midrst.release");

`ifndef UART_TX_HOLD_BUF_EN
    // Mid-frame Data_Valid with 0x3C plus PAR_EN/PAR_TYP flips: ignored.
    send(8'hA5, 1'b1, 1'b0);
    run_frame("ignore", 8'hA5, 1'b1, 1'b0, 3, 8'h3C);
    par_en  = 1'b0;
    par_typ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("ignore.idle%0d", i));
      check_eq($sformatf("ignore.buf%0d", i), buf_full, 1'b0);
    end

    // Data_Valid held high: 0xFF, no parity, period 11 (10 busy + 1 idle).
    p_data     = 8'hFF;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    tick();
    start_cycle = cycle;
    run_frame("held0", 8'hFF, 1'b0, 1'b0, -1, 8'h00);
    tick();
    check_eq("held.period1", cycle - start_cycle, 11);
    start_cycle = cycle;
    run_frame("held1", 8'hFF, 1'b0, 1'b0, -1, 8'h00);
    tick();
    check_eq("held.period2", cycle - start_cycle, 11);
    check_eq("held.start3_mux", mux_sel, 2'b00);
    data_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_idle("held.end");
`else
    // Holding register: 0x01 in flight, 0x80 queued, 0x55 dropped.
    send(8'h01, 1'b0, 1'b0);
    tick();                                   // D0
    tick();                                   // D1
    p_data     = 8'h80;
    data_valid = 1'b1;
    tick();                                   // D2, 0x80 captured
    check_eq("buf.after_q80", buf_full, 1'b1);
    p_data = 8'h55;
    tick();                                   // D3, 0x55 offered while full
    data_valid = 1'b0;
    check_eq("buf.still_full", buf_full, 1'b1);
    check_eq("buf.first_ser3", ser_data, 1'b0);
    for (int i = 0; i < 4; i++) tick();       // D4..D7
    tick();                                   // STOP of 0x01
    check_eq("buf.stop_mux",  mux_sel,  2'b11);
    check_eq("buf.stop_busy", busy,     1'b1);
    check_eq("buf.stop_full", buf_full, 1'b1);
    tick();                                   // START of 0x80, no idle gap
    check_eq("buf.b2b_full", buf_full, 1'b0);
    run_frame("buf_x80", 8'h80, 1'b0, 1'b1, -1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("buf.idle%0d", i));
      check_eq($sformatf("buf.empty%0d", i), buf_full, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, required finished)");
    $fatal(1, "timeout");
  end

endmodule
